// File: rtl/rtt_probe_gen_pkg.sv
// Shared definitions for the RTT probe generator: IO-queue header field
// positions, control-word constants and arbiter state encodings.
package rtt_probe_gen_pkg;

    localparam int IOQ_BYTE_LEN_POS = 0;
    localparam int IOQ_SRC_PORT_POS = 16;
    localparam int IOQ_WORD_LEN_POS = 32;
    localparam int IOQ_DST_PORT_POS = 48;

    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;
    localparam logic [7:0] LAST_WORD_CTRL     = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PASS   = 3'd1,
        ST_P_HDR  = 3'd2,
        ST_P_DATA = 3'd3,
        ST_P_LAST = 3'd4
    } arb_state_e;

    function automatic logic [63:0] probe_header(input logic [15:0] dst_port,
                                                 input logic [15:0] word_len,
                                                 input logic [15:0] src_port,
                                                 input logic [15:0] byte_len);
        logic [63:0] hdr;
        hdr = '0;
        hdr[IOQ_DST_PORT_POS +: 16] = dst_port;
        hdr[IOQ_WORD_LEN_POS +: 16] = word_len;
        hdr[IOQ_SRC_PORT_POS +: 16] = src_port;
        hdr[IOQ_BYTE_LEN_POS +: 16] = byte_len;
        return hdr;
    endfunction

endpackage

// File: rtl/rtt_probe_gen_fifo.sv
// Small fall-through FIFO used as the pass-through input buffer; the head
// word is visible on dout_o whenever empty_o is low.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             nearly_full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] CNT_FULL  = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] CNT_NFULL = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   count_q, count_d;
    logic                      do_wr, do_rd;

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o        = mem_q[rd_ptr_q];
    assign full_o        = (count_q == CNT_FULL);
    assign nearly_full_o = (count_q >= CNT_NFULL);
    assign empty_o       = (count_q == '0);

endmodule

// File: rtl/rtt_probe_gen.sv
// Periodic RTT probe injector merged with pass-through traffic at packet
// boundaries. Define RTT_PROBE_GEN_MISS_CNT_EN to build the missed-probe counter.
//
// state  | meaning
// IDLE   | between packets; probe request wins over queued traffic
// PASS   | forwarding a user packet until its end-of-packet word
// P_HDR  | emitting the probe module header, latching seq and timestamp
// P_DATA | emitting probe body words (index 1 carries seq/timestamp)
// P_LAST | emitting the final probe word, pulsing probe_sent
module rtt_probe_gen
    import rtt_probe_gen_pkg::*;
#(
    parameter int          DATA_WIDTH     = 64,
    parameter int          CTRL_WIDTH     = DATA_WIDTH/8,
    parameter int          PROBE_WORDS    = 8,
    parameter logic [15:0] PROBE_SRC_PORT = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  probe_en,
    input  logic [31:0]           probe_interval,
    input  logic [15:0]           probe_dst_port,
    input  logic [31:0]           time_now,
    output logic                  probe_sent,
    output logic [15:0]           probe_missed
);

    localparam int               IDX_W    = $clog2(PROBE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PROBE_WORDS - 2);

    arb_state_e                  state_q;
    logic [IDX_W-1:0]            idx_q;
    logic                        in_body_q;
    logic [31:0]                 seq_lat_q, ts_q;
    logic [DATA_WIDTH-1:0]       out_data_q;
    logic [CTRL_WIDTH-1:0]       out_ctrl_q;
    logic                        out_wr_q, probe_sent_q;

    logic [31:0]                 icnt_q, icnt_d;
    logic [31:0]                 seq_q, seq_d;
    logic                        pending_q, pending_d;
    logic                        expire, hdr_go, last_go;

    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
    logic [DATA_WIDTH-1:0]       head_data;
    logic [CTRL_WIDTH-1:0]       head_ctrl;
    logic                        fifo_full, fifo_nearly_full, fifo_empty, fifo_rd;
    logic [DATA_WIDTH-1:0]       hdr_word;

    fallthrough_small_fifo #(
        .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
        .MAX_DEPTH_BITS (2)
    ) u_in_fifo (
        .clk           (clk),
        .reset         (reset),
        .din_i         ({in_ctrl, in_data}),
        .wr_en_i       (in_wr),
        .rd_en_i       (fifo_rd),
        .dout_o        (fifo_dout),
        .full_o        (fifo_full),
        .nearly_full_o (fifo_nearly_full),
        .empty_o       (fifo_empty)
    );

    assign in_rdy    = !fifo_nearly_full && !fifo_full;
    assign head_data = fifo_dout[DATA_WIDTH-1:0];
    assign head_ctrl = fifo_dout[DATA_WIDTH +: CTRL_WIDTH];
    assign hdr_word  = DATA_WIDTH'(probe_header(probe_dst_port, 16'(PROBE_WORDS),
                                                PROBE_SRC_PORT, 16'(PROBE_WORDS*8)));

    assign hdr_go  = (state_q == ST_P_HDR)  && out_rdy;
    assign last_go = (state_q == ST_P_LAST) && out_rdy;

    always_comb begin
        fifo_rd = 1'b0;
        case (state_q)
            ST_IDLE: fifo_rd = !pending_q && !fifo_empty && out_rdy;
            ST_PASS: fifo_rd = !fifo_empty && out_rdy;
            default: fifo_rd = 1'b0;
        endcase
    end

    // An expiry in the same cycle as the header clears the old request but
    // must still leave a fresh one behind.
    always_comb begin
        expire = 1'b0;
        icnt_d = icnt_q;
        if (!probe_en || (probe_interval == 32'd0)) begin
            icnt_d = '0;
        end else if (icnt_q == (probe_interval - 32'd1)) begin
            icnt_d = '0;
            expire = 1'b1;
        end else begin
            icnt_d = icnt_q + 32'd1;
        end

        pending_d = pending_q;
        if (hdr_go) pending_d = 1'b0;
        if (expire) pending_d = 1'b1;

        seq_d = last_go ? (seq_q + 32'd1) : seq_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icnt_q    <= '0;
            pending_q <= 1'b0;
            seq_q     <= '0;
        end else begin
            icnt_q    <= icnt_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
        end
    end

`ifdef RTT_PROBE_GEN_MISS_CNT_EN
    logic [15:0] missed_q, missed_d;

    always_comb begin
        missed_d = missed_q;
        if (expire && pending_q && !hdr_go && (missed_q != 16'hFFFF)) begin
            missed_d = missed_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            missed_q <= '0;
        end else begin
            missed_q <= missed_d;
        end
    end

    assign probe_missed = missed_q;
`else
    assign probe_missed = 16'h0000;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            in_body_q    <= 1'b0;
            seq_lat_q    <= '0;
            ts_q         <= '0;
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            out_wr_q     <= 1'b0;
            probe_sent_q <= 1'b0;
        end else begin
            out_wr_q     <= 1'b0;
            probe_sent_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pending_q && out_rdy) begin
                        state_q <= ST_P_HDR;
                    end else if (fifo_rd) begin
                        out_data_q <= head_data;
                        out_ctrl_q <= head_ctrl;
                        out_wr_q   <= 1'b1;
                        in_body_q  <= (head_ctrl == '0);
                        state_q    <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (fifo_rd) begin
                        out_data_q <= head_data;
                        out_ctrl_q <= head_ctrl;
                        out_wr_q   <= 1'b1;
                        if (head_ctrl == '0) begin
                            in_body_q <= 1'b1;
                        end else if (in_body_q) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_P_HDR: begin
                    if (out_rdy) begin
                        out_data_q <= hdr_word;
                        out_ctrl_q <= CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);
                        out_wr_q   <= 1'b1;
                        seq_lat_q  <= seq_q;
                        ts_q       <= time_now;
                        idx_q      <= '0;
                        state_q    <= ST_P_DATA;
                    end
                end
                ST_P_DATA: begin
                    if (out_rdy) begin
                        out_data_q <= (idx_q == IDX_W'(1)) ? DATA_WIDTH'({seq_lat_q, ts_q}) : '0;
                        out_ctrl_q <= '0;
                        out_wr_q   <= 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_P_LAST;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_P_LAST: begin
                    if (out_rdy) begin
                        out_data_q   <= '0;
                        out_ctrl_q   <= CTRL_WIDTH'(LAST_WORD_CTRL);
                        out_wr_q     <= 1'b1;
                        probe_sent_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_ctrl   = out_ctrl_q;
    assign out_wr     = out_wr_q;
    assign probe_sent = probe_sent_q;

endmodule

// File: tb/tb_rtt_probe_gen.sv
// Directed scoreboard bench for rtt_probe_gen: expected words are queued as
// stimulus is applied and compared as they leave the merged output.
module tb_rtt_probe_gen;

    localparam int          PW  = 8;
    localparam logic [15:0] DST = 16'h0004;
`ifdef RTT_PROBE_GEN_MISS_CNT_EN
    localparam logic [15:0] EXP_MISS = 16'd7;
`else
    localparam logic [15:0] EXP_MISS = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic        probe_en = 1'b0;
    logic [31:0] probe_interval = '0;
    logic [15:0] probe_dst_port = DST;
    logic [31:0] time_now = 32'h1234_0000;
    logic        probe_sent;
    logic [15:0] probe_missed;

    rtt_probe_gen dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_ctrl        (in_ctrl),
        .in_wr          (in_wr),
        .in_rdy         (in_rdy),
        .out_data       (out_data),
        .out_ctrl       (out_ctrl),
        .out_wr         (out_wr),
        .out_rdy        (out_rdy),
        .probe_en       (probe_en),
        .probe_interval (probe_interval),
        .probe_dst_port (probe_dst_port),
        .time_now       (time_now),
        .probe_sent     (probe_sent),
        .probe_missed   (probe_missed)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        time_now <= time_now + 32'd1;
    end

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        bit          sent;
        bit          ts;
        bit          hdr;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          hdr_cnt  = 0;
    int          sent_cnt = 0;
    int unsigned hdr_cyc  = 0;
    logic [31:0] hdr_time = '0;
    int          plen     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_probe(input logic [31:0] s);
        exp_t e;
        e = '{data: {DST, 16'(PW), 16'h0000, 16'(PW*8)}, ctrl: 8'hFF, sent: 0, ts: 0, hdr: 1};
        sb.push_back(e);
        for (int k = 0; k < PW-1; k++) begin
            e = '{data: (k == 1) ? {s, 32'h0} : 64'h0, ctrl: 8'h00, sent: 0, ts: (k == 1), hdr: 0};
            sb.push_back(e);
        end
        e = '{data: 64'h0, ctrl: 8'h80, sent: 1, ts: 0, hdr: 0};
        sb.push_back(e);
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while (!in_rdy && guard < 50) begin
                in_wr = 1'b0;
                @(negedge clk);
                guard++;
            end
            if (!in_rdy) chk("in_rdy_timeout", in_rdy, 1);
            in_data = {base, 32'(i)};
            in_ctrl = (i == 0) ? 8'hFF : ((i == n-1) ? 8'h80 : 8'h00);
            in_wr   = 1'b1;
            e = '{data: in_data, ctrl: in_ctrl, sent: 0, ts: 0, hdr: 0};
            sb.push_back(e);
            @(negedge clk);
        end
        in_wr = 1'b0;
    endtask

    task automatic pulse_en(input logic [31:0] ival, input int edges);
        @(negedge clk);
        probe_interval = ival;
        probe_en = 1'b1;
        repeat (edges) @(negedge clk);
        probe_en = 1'b0;
    endtask

    task automatic wait_hdr(input int target, input int limit, input string tag);
        int n = 0;
        while (hdr_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (hdr_cnt >= target), 1);
    endtask

    task automatic drain(input int limit, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Output monitor: every written word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (out_wr) begin
                chk("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.ts) e.data[31:0] = hdr_time;
                    chk("out_ctrl", out_ctrl, e.ctrl);
                    chk("out_data", out_data, e.data);
                    chk("probe_sent", probe_sent, e.sent);
                    if (e.hdr) begin
                        hdr_time = time_now - 32'd1;
                        hdr_cyc  = cyc;
                        hdr_cnt++;
                        plen = 1;
                    end else begin
                        plen++;
                    end
                    if (e.sent) begin
                        chk("probe_len", plen, PW + 1);
                        sent_cnt++;
                    end
                end
            end else begin
                chk("sent_idle", probe_sent, 0);
            end
        end
    end

    initial begin
        int unsigned c0, h1;
        int          s0;

        // reset state
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_wr", out_wr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_probe_sent", probe_sent, 0);
        chk("rst_missed", probe_missed, 0);
        chk("rst_in_rdy", in_rdy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // periodic probes on an idle path
        push_probe(32'd0);
        push_probe(32'd1);
        probe_interval = 32'd100;
        probe_en = 1'b1;
        c0 = cyc;
        wait_hdr(1, 150, "hdr1_timeout");
        h1 = hdr_cyc;
        chk("first_hdr_latency", h1 - c0, 102);
        wait_hdr(2, 150, "hdr2_timeout");
        chk("probe_period", hdr_cyc - h1, 100);
        probe_en = 1'b0;
        drain(50, "drain_periodic");

        // probe requested mid-packet waits for end of packet
        probe_interval = 32'd6;
        probe_en = 1'b1;
        send_pkt(10, 32'hA000_0000);
        probe_en = 1'b0;
        push_probe(32'd2);
        drain(60, "drain_midpkt");

        // probe and queued packet together in IDLE: probe first
        out_rdy = 1'b0;
        push_probe(32'd3);
        pulse_en(32'd2, 2);
        send_pkt(3, 32'hB000_0000);
        @(negedge clk);
        out_rdy = 1'b1;
        drain(60, "drain_tie");

        // backpressure during P_DATA
        push_probe(32'd4);
        s0 = hdr_cnt;
        pulse_en(32'd4, 4);
        wait_hdr(s0 + 1, 20, "hdr_bp_timeout");
        repeat (2) @(negedge clk);
        out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        out_rdy = 1'b1;
        drain(40, "drain_bp");

        // missed expiries while output is stalled
        s0 = sent_cnt;
        @(negedge clk);
        out_rdy = 1'b0;
        probe_interval = 32'd5;
        probe_en = 1'b1;
        repeat (40) @(negedge clk);
        chk("missed_after_stall", probe_missed, EXP_MISS);
        probe_en = 1'b0;
        push_probe(32'd5);
        out_rdy = 1'b1;
        drain(40, "drain_stall");
        chk("single_probe_after_stall", sent_cnt - s0, 1);
        chk("missed_hold", probe_missed, EXP_MISS);

        // sequence number wrap
        @(negedge clk);
        force dut.seq_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.seq_q;
        push_probe(32'hFFFF_FFFF);
        pulse_en(32'd3, 3);
        drain(40, "drain_wrap1");
        push_probe(32'h0000_0000);
        pulse_en(32'd3, 3);
        drain(40, "drain_wrap2");

        // reset in the middle of a probe
        push_probe(32'd1);
        s0 = hdr_cnt;
        pulse_en(32'd3, 3);
        wait_hdr(s0 + 1, 20, "hdr_rst_timeout");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_wr", out_wr, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_ctrl", out_ctrl, 0);
        chk("midrst_probe_sent", probe_sent, 0);
        @(posedge clk);
        #1;
        chk("midrst_out_wr_edge", out_wr, 0);
        chk("midrst_missed", probe_missed, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        push_probe(32'd0);
        pulse_en(32'd3, 3);
        drain(40, "drain_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
